deserializer_multi: RTL and testbench
=====================================

// Module: deserializer_multi
// PURPOSE
//  Parametrised successor of the parallel-collect deserializer: gathers a runtime-selected
//  number of BIT_WIDTH samples from a val/rdy stream into one flattened frame. Frames are
//  double-buffered, so the next frame fills while the previous one waits on send_rdy.
//  Sits between the SERDES receive path and the downstream parallel processing blocks.
// PARAMETERS
//  BIT_WIDTH   32  width of one sample
//  N_SAMPLES    8  maximum samples per frame (>=2)
//  CNT_W       $clog2(N_SAMPLES+1)  width of length fields (derived; do not override)
// PORTS
//  clk       in   1                    clock; all logic on posedge
//  reset     in   1                    synchronous, active-high
//  cfg_len   in   CNT_W                samples per frame; 0 or >N_SAMPLES means N_SAMPLES
//  recv_msg  in   BIT_WIDTH            input sample
//  recv_val  in   1                    input valid
//  recv_rdy  out  1                    input ready
//  send_msg  out  N_SAMPLES*BIT_WIDTH  frame; sample i at [i*BIT_WIDTH +: BIT_WIDTH]
//  send_len  out  CNT_W                number of valid samples in send_msg
//  send_val  out  1                    frame valid
//  send_rdy  in   1                    frame ready
//  flush     in   1                    only when DESER_FLUSH_EN defined
// BEHAVIOUR
//  - Reset: recv_rdy=1 in the cycle after reset drops; send_val=0; send_msg=0; send_len=0.
//    Fill count=0; fill buffer cleared; any partially filled frame is discarded.
//  - Transfers: accepted on the clock edge when val&&rdy; no combinational path from
//    recv_val to recv_rdy; recv_rdy is a function of registered state only.
//  - Fill side states: FILL (recv_rdy=1) and HOLD (frame complete, output busy, recv_rdy=0).
//  - cfg_len is latched into len_q when the first sample of a frame is accepted (count==0);
//    changing cfg_len mid-frame does not affect the frame being filled.
//  - Sample k of a frame is written to slot k; slots >= len are zero in send_msg.
//  - Frame completes when the sample at count==len_q-1 is accepted. If the output register
//    is empty, or send_val&&send_rdy in the same cycle, the frame moves to the output
//    register: send_val=1 the next cycle (latency 1 from last sample) and FILL continues
//    with count=0. Otherwise go to HOLD.
//  - HOLD -> FILL on the cycle send_val&&send_rdy: the held frame loads the output register
//    at that edge (back-to-back frames, no bubble); recv_rdy=1 the next cycle.
//  - send_msg/send_len stay stable while send_val=1 and send_rdy=0.
//  - cfg_len==1: every accepted sample forms a frame; sustained throughput 1 sample/cycle
//    with send_rdy held high.
//  - Count never exceeds len_q-1; there is no wrap past N_SAMPLES.
// CONFIGURATION
//  DESER_FLUSH_EN defined: flush port exists. flush=1 in FILL with count>0 (or a sample
//   accepted the same cycle) closes the frame early; a sample accepted that cycle is
//   included; send_len=samples collected; remaining slots zero. flush with nothing
//   collected, or in HOLD, is ignored.
//  DESER_FLUSH_EN undefined: no flush port; frames close only at len_q.
// STRUCTURE
//  - Package deser_pkg: typedef enum logic {FILL, HOLD} deser_fill_e; function
//    eff_len(cfg, N) implementing the 0/oversize clamp.
//  - Sub-module deser_out_reg: one-entry val/rdy output register (msg+len), load/drain.
//  - Top: fill buffer, count, len_q, fill FSM, cfg clamp, zero-masking of unused slots.
// TESTING
//  1. N=8, cfg_len=8, samples 1..8, send_rdy=1 -> one frame slots 1..8, send_len=8,
//     send_val 1 cycle after sample 8.
//  2. cfg_len=3, samples A,B,C -> slots0-2=A,B,C, slots3-7=0, send_len=3; cfg_len=0 -> len 8.
//  3. send_rdy=0, stream 16 samples at cfg_len=8 -> frame1 on output, frame2 held,
//     recv_rdy=0; raise send_rdy -> frame1 then frame2 on consecutive cycles.
//  4. cfg_len changed 4->2 after sample 2 of a 4-frame -> frame has 4 samples; next has 2.
//  5. Reset asserted after 5 of 8 samples -> send_val=0, next 8 samples form a clean frame.
//  6. DESER_FLUSH_EN: cfg_len=8, flush with sample 3 -> send_len=3, slots3-7=0.

Source files
------------

// File: rtl/deser_pkg.sv
// Shared types and helpers for the multi-sample deserializer.
// Optional feature macro used by the top level: DESER_FLUSH_EN.
package deser_pkg;

    // Fill side: FILL accepts samples, HOLD parks a finished frame behind a busy output.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } deser_fill_e;

    // Effective frame length: 0 or anything above the maximum selects the maximum.
    function automatic int unsigned eff_len(input int unsigned cfg, input int unsigned n);
        if (cfg == 0 || cfg > n) begin
            return n;
        end
        return cfg;
    endfunction

endpackage

// File: rtl/deser_out_reg.sv
// One-entry valid/ready output register holding a finished frame and its length.
// can_load tells the producer a new frame may be written at this edge.
module deser_out_reg #(
    parameter int MSG_W = 256,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [MSG_W-1:0] load_msg,
    input  logic [LEN_W-1:0] load_len,
    output logic             can_load,
    output logic             send_val,
    output logic [MSG_W-1:0] send_msg,
    output logic [LEN_W-1:0] send_len,
    input  logic             send_rdy
);

    logic             val_reg;
    logic [MSG_W-1:0] msg_reg;
    logic [LEN_W-1:0] len_reg;

    // Load wins over drain so a frame can replace the one leaving this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            val_reg <= 1'b0;
            msg_reg <= '0;
            len_reg <= '0;
        end else if (load) begin
            val_reg <= 1'b1;
            msg_reg <= load_msg;
            len_reg <= load_len;
        end else if (send_rdy) begin
            val_reg <= 1'b0;
        end
    end

    assign can_load = !val_reg || send_rdy;
    assign send_val = val_reg;
    assign send_msg = msg_reg;
    assign send_len = len_reg;

endmodule

// File: rtl/deser_multi.sv
// Multi-sample deserializer: collects a runtime-selected number of samples into a
// flattened frame, double-buffered against a one-entry output register.
// Optional feature: define DESER_FLUSH_EN to add the flush port (early frame close).
module deserializer_multi
    import deser_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8,
    parameter int CNT_W     = $clog2(N_SAMPLES + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CNT_W-1:0]               cfg_len,
    input  logic [BIT_WIDTH-1:0]           recv_msg,
    input  logic                           recv_val,
    output logic                           recv_rdy,
    output logic [N_SAMPLES*BIT_WIDTH-1:0] send_msg,
    output logic [CNT_W-1:0]               send_len,
    output logic                           send_val,
`ifdef DESER_FLUSH_EN
    input  logic                           flush,
`endif
    input  logic                           send_rdy
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    deser_fill_e            state_reg;
    deser_fill_e            state_next;
    logic [CNT_W-1:0]       count_reg;
    logic [CNT_W-1:0]       len_reg;
    logic [CNT_W-1:0]       hold_len_reg;
    logic [BIT_WIDTH-1:0]   buf_reg [N_SAMPLES];
    logic [BIT_WIDTH-1:0]   slot_data [N_SAMPLES];

    logic                   accept;
    logic [CNT_W-1:0]       first_len;
    logic [CNT_W-1:0]       cur_len;
    logic                   last;
    logic                   flush_close;
    logic                   close;
    logic [CNT_W-1:0]       close_len;
    logic                   can_load;
    logic                   load;
    logic [CNT_W-1:0]       frame_len;
    logic [N_SAMPLES*BIT_WIDTH-1:0] frame_msg;

    assign accept    = recv_val && recv_rdy;
    assign first_len = CNT_W'(eff_len(int'(cfg_len), N_SAMPLES));
    // The length is taken from cfg_len only for the first sample; afterwards it is frozen.
    assign cur_len   = (count_reg == '0) ? first_len : len_reg;
    assign last      = accept && (count_reg == (cur_len - ONE));
    // Samples collected including one accepted this cycle; equals cur_len when last.
    assign close_len = count_reg + (accept ? ONE : '0);

`ifdef DESER_FLUSH_EN
    assign flush_close = flush && (state_reg == FILL) && ((count_reg != '0) || accept);
`else
    assign flush_close = 1'b0;
`endif

    assign close = (state_reg == FILL) && (last || flush_close);

    // Fill state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: park a closed frame when the output cannot take it, release on drain.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FILL:    if (close && !can_load) state_next = HOLD;
            HOLD:    if (can_load)           state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // Outputs of the fill FSM: input ready and output register load strobe.
    always_comb begin
        recv_rdy  = (state_reg == FILL);
        load      = 1'b0;
        frame_len = hold_len_reg;
        case (state_reg)
            FILL: begin
                load      = close && can_load;
                frame_len = close_len;
            end
            HOLD: begin
                load      = can_load;
                frame_len = hold_len_reg;
            end
            default: ;
        endcase
    end

    // Count, latched frame length and held-frame length.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg    <= '0;
            len_reg      <= '0;
            hold_len_reg <= '0;
        end else if (state_reg == FILL) begin
            if (close) begin
                count_reg    <= '0;
                hold_len_reg <= close_len;
            end else if (accept) begin
                count_reg <= count_reg + ONE;
            end
            if (accept && (count_reg == '0)) begin
                len_reg <= first_len;
            end
        end
    end

    // Per-slot storage, bypass of the sample arriving this cycle, and zero-masking.
    generate
        for (genvar gi = 0; gi < N_SAMPLES; gi++) begin : g_slot
            // Slot gi captures the sample accepted while count points at it.
            always_ff @(posedge clk) begin
                if (reset) begin
                    buf_reg[gi] <= '0;
                end else if (accept && (count_reg == CNT_W'(gi))) begin
                    buf_reg[gi] <= recv_msg;
                end
            end

            assign slot_data[gi] = (accept && (count_reg == CNT_W'(gi))) ? recv_msg : buf_reg[gi];
            assign frame_msg[gi*BIT_WIDTH +: BIT_WIDTH] =
                (CNT_W'(gi) < frame_len) ? slot_data[gi] : '0;
        end
    endgenerate

    deser_out_reg #(
        .MSG_W (N_SAMPLES*BIT_WIDTH),
        .LEN_W (CNT_W)
    ) u_out (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_msg (frame_msg),
        .load_len (frame_len),
        .can_load (can_load),
        .send_val (send_val),
        .send_msg (send_msg),
        .send_len (send_len),
        .send_rdy (send_rdy)
    );

endmodule

// File: tb/tb_deserializer_multi.sv
// Self-checking bench for deserializer_multi: directed scenarios followed by random
// traffic, checked against a queue-based frame model. Honours DESER_FLUSH_EN.
module tb_deserializer_multi;

    localparam int W  = 32;
    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic [CW-1:0]     cfg_len;
    logic [W-1:0]      recv_msg;
    logic              recv_val;
    logic              recv_rdy;
    logic [N*W-1:0]    send_msg;
    logic [CW-1:0]     send_len;
    logic              send_val;
    logic              send_rdy;
`ifdef DESER_FLUSH_EN
    logic              flush;
`endif

    deserializer_multi #(.BIT_WIDTH(W), .N_SAMPLES(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_len  (cfg_len),
        .recv_msg (recv_msg),
        .recv_val (recv_val),
        .recv_rdy (recv_rdy),
        .send_msg (send_msg),
        .send_len (send_len),
        .send_val (send_val),
`ifdef DESER_FLUSH_EN
        .flush    (flush),
`endif
        .send_rdy (send_rdy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: frames completed but not yet delivered, and the frame being collected.
    logic [N*W-1:0] exp_msg_q[$];
    int             exp_len_q[$];
    logic [W-1:0]   cur_s [N];
    int             cur_n;
    int             cur_len;
    int             pending;

    function automatic int eff(input int c);
        return (c == 0 || c > N) ? N : c;
    endfunction

    task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_msg_q.delete();
        exp_len_q.delete();
        cur_n   = 0;
        cur_len = 0;
        pending = 0;
    endtask

    task automatic model_close();
        logic [N*W-1:0] m;
        m = '0;
        for (int i = 0; i < cur_n; i++) m[i*W +: W] = cur_s[i];
        exp_msg_q.push_back(m);
        exp_len_q.push_back(cur_n);
        cur_n = 0;
        pending++;
    endtask

    // One clock: drive inputs, check state, advance the model across the edge.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic sr,
                         input logic [CW-1:0] cfg, input logic fl);
        logic fire;
        logic acc;
        recv_val = v;
        recv_msg = d;
        send_rdy = sr;
        cfg_len  = cfg;
`ifdef DESER_FLUSH_EN
        flush    = fl;
`endif
        #1;
        chk("recv_rdy", N*W'(recv_rdy), N*W'(pending < 2));
        chk("send_val", N*W'(send_val), N*W'(pending > 0));
        fire = send_val && send_rdy;
        acc  = recv_val && recv_rdy;
        if (fire) begin
            if (exp_len_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_frame: observed len %0d expected no frame", send_len);
            end else begin
                chk("send_msg", send_msg, exp_msg_q.pop_front());
                chk("send_len", N*W'(send_len), N*W'(exp_len_q.pop_front()));
                pending--;
            end
        end
        if (acc) begin
            if (cur_n == 0) cur_len = eff(int'(cfg));
            cur_s[cur_n] = d;
            cur_n++;
            if (cur_n == cur_len) model_close();
        end
`ifdef DESER_FLUSH_EN
        if (fl && recv_rdy && cur_n > 0) model_close();
`else
        if (fl) cur_len = cur_len;
`endif
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        recv_val = 1'b0;
        recv_msg = '0;
        send_rdy = 1'b0;
        cfg_len  = CW'(8);
`ifdef DESER_FLUSH_EN
        flush    = 1'b0;
`endif
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        chk("rst_send_val", N*W'(send_val), '0);
        chk("rst_send_msg", send_msg, '0);
        chk("rst_send_len", N*W'(send_len), '0);
        chk("rst_recv_rdy", N*W'(recv_rdy), N*W'(1));
    endtask

    initial begin
        do_reset();

        // Full 8-sample frame, output always ready.
        for (int i = 1; i <= 8; i++) cycle(1'b1, W'(i), 1'b1, CW'(8), 1'b0);
        chk("t1_latency", N*W'(send_val), N*W'(1));
        cycle(1'b0, '0, 1'b1, CW'(8), 1'b0);

        // Short frame of 3, then cfg_len=0 selects the maximum.
        cycle(1'b1, 32'h0000_00AA, 1'b1, CW'(3), 1'b0);
        cycle(1'b1, 32'h0000_00BB, 1'b1, CW'(3), 1'b0);
        cycle(1'b1, 32'h0000_00CC, 1'b1, CW'(3), 1'b0);
        cycle(1'b0, '0, 1'b1, CW'(3), 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, W'(32'h100 + i), 1'b1, CW'(0), 1'b0);
        cycle(1'b0, '0, 1'b1, CW'(0), 1'b0);

        // Output stalled: one frame on the output, one held, input blocked.
        for (int i = 0; i < 18; i++) cycle(1'b1, W'(32'h200 + i), 1'b0, CW'(8), 1'b0);
        chk("t3_stalled", N*W'(recv_rdy), '0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, CW'(8), 1'b0);

        // cfg_len changed mid-frame has no effect until the next frame.
        cycle(1'b1, W'(32'h301), 1'b1, CW'(4), 1'b0);
        cycle(1'b1, W'(32'h302), 1'b1, CW'(4), 1'b0);
        cycle(1'b1, W'(32'h303), 1'b1, CW'(2), 1'b0);
        cycle(1'b1, W'(32'h304), 1'b1, CW'(2), 1'b0);
        cycle(1'b1, W'(32'h305), 1'b1, CW'(2), 1'b0);
        cycle(1'b1, W'(32'h306), 1'b1, CW'(2), 1'b0);
        cycle(1'b0, '0, 1'b1, CW'(2), 1'b0);

        // Reset in the middle of a frame discards it.
        for (int i = 0; i < 5; i++) cycle(1'b1, W'(32'h400 + i), 1'b1, CW'(8), 1'b0);
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, W'(32'h500 + i), 1'b1, CW'(8), 1'b0);
        cycle(1'b0, '0, 1'b1, CW'(8), 1'b0);

        // Single-sample frames at full rate.
        for (int i = 0; i < 6; i++) cycle(1'b1, W'(32'h600 + i), 1'b1, CW'(1), 1'b0);
        cycle(1'b0, '0, 1'b1, CW'(1), 1'b0);

`ifdef DESER_FLUSH_EN
        // Early close with the third sample; flush with nothing collected is ignored.
        cycle(1'b0, '0, 1'b1, CW'(8), 1'b1);
        cycle(1'b1, W'(32'h701), 1'b1, CW'(8), 1'b0);
        cycle(1'b1, W'(32'h702), 1'b1, CW'(8), 1'b0);
        cycle(1'b1, W'(32'h703), 1'b1, CW'(8), 1'b1);
        chk("t6_flush_len", N*W'(send_len), N*W'(3));
        cycle(1'b0, '0, 1'b1, CW'(8), 1'b0);
`endif

        // Random traffic including oversize cfg_len and backpressure.
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), W'($urandom),
                  1'($urandom_range(0, 2) != 0), CW'($urandom_range(0, 15)),
                  1'($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, CW'(8), 1'b0);
        chk("drain_empty", N*W'(exp_len_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
